// File: rtl/skew_feed_pkg.sv
// Shared state type and sizing helpers for the skew feed buffer.
package skew_feed_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int SKEW_DIM_DEFAULT   = 8;
  localparam int SKEW_CNT_W_DEFAULT = $clog2(2*SKEW_DIM_DEFAULT-1);

  function automatic int skew_len(input int dim);
    return 2*dim - 1;
  endfunction

  function automatic int skew_cnt_w(input int dim);
    return (dim > 1) ? $clog2(2*dim - 1) : 1;
  endfunction

endpackage

// File: rtl/skew_feed_buf_row.sv
// One row of the skew buffer: LEN-deep data+valid shift register whose parallel
// load places element k at entry ROW+k. SKEW_FEED_TRANSPOSE_EN adds a single-entry poke.
module skew_row_shreg
  import skew_feed_pkg::*;
#(
  parameter int BITS = 8,
  parameter int DIM  = 8,
  parameter int ROW  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_i,
  input  logic                   clr_i,
  input  logic                   shift_i,
  input  logic signed [BITS-1:0] row_i [DIM],
`ifdef SKEW_FEED_TRANSPOSE_EN
  input  logic                   poke_i,
  input  logic [skew_cnt_w(DIM)-1:0] poke_idx_i,
  input  logic signed [BITS-1:0] poke_data_i,
`endif
  output logic signed [BITS-1:0] head_o,
  output logic                   head_vld_o
);

  localparam int LEN = skew_len(DIM);

  logic signed [BITS-1:0] dat_q [LEN];
  logic signed [BITS-1:0] dat_d [LEN];
  logic [LEN-1:0]         vld_q, vld_d;

  always_comb begin
    dat_d = dat_q;
    vld_d = vld_q;
    if (clr_i) begin
      for (int i = 0; i < LEN; i++) dat_d[i] = '0;
      vld_d = '0;
    end else if (load_i) begin
      for (int i = 0; i < LEN; i++) dat_d[i] = '0;
      vld_d = '0;
      for (int k = 0; k < DIM; k++) begin
        dat_d[ROW+k] = row_i[k];
        vld_d[ROW+k] = 1'b1;
      end
    end
`ifdef SKEW_FEED_TRANSPOSE_EN
    else if (poke_i) begin
      dat_d[poke_idx_i] = poke_data_i;
      vld_d[poke_idx_i] = 1'b1;
    end
`endif
    else if (shift_i) begin
      for (int i = 0; i < LEN-1; i++) dat_d[i] = dat_q[i+1];
      dat_d[LEN-1] = '0;
      vld_d        = vld_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LEN; i++) dat_q[i] <= '0;
      vld_q <= '0;
    end else begin
      for (int i = 0; i < LEN; i++) dat_q[i] <= dat_d[i];
      vld_q <= vld_d;
    end
  end

  assign head_o     = dat_q[0];
  assign head_vld_o = vld_q[0];

endmodule

// File: rtl/skew_feed_buf.sv
// Operand skew buffer: loads a DIMxDIM tile by rows, streams row r delayed by r cycles.
// Define SKEW_FEED_TRANSPOSE_EN to add wr_col (column writes, transposed load).
//
// state  | meaning
// IDLE   | accepting row writes, waiting for start
// STREAM | shifting all rows toward the heads, LEN cycles
// DONE   | one-cycle done pulse, tile discarded
module skew_feed_buf
  import skew_feed_pkg::*;
#(
  parameter int BITS = 8,
  parameter int DIM  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [$clog2(DIM)-1:0]  wr_row,
`ifdef SKEW_FEED_TRANSPOSE_EN
  input  logic                    wr_col,
`endif
  input  logic signed [BITS-1:0]  din [DIM],
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic signed [BITS-1:0]  dout [DIM],
  output logic [DIM-1:0]          dout_vld,
  output logic                    wr_drop
);

  localparam int LEN = skew_len(DIM);
  localparam int CW  = skew_cnt_w(DIM);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DIM-1:0] loaded_q, loaded_d;
  logic           wr_drop_q, wr_drop_d;
  logic           row_ok, wr_ok, col_w, shift, clr;

  logic signed [BITS-1:0] head [DIM];
  logic [DIM-1:0]         head_vld;

`ifdef SKEW_FEED_TRANSPOSE_EN
  assign col_w = wr_col;
`else
  assign col_w = 1'b0;
`endif

  // Non-power-of-two DIM leaves row codes that do not exist; those writes drop.
  assign row_ok = int'(wr_row) < DIM;
  assign wr_ok  = wr_en && row_ok && (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    loaded_d  = loaded_q;
    wr_drop_d = wr_en && !wr_ok;
    busy      = 1'b0;
    done      = 1'b0;
    shift     = 1'b0;
    clr       = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_ok) begin
          if (col_w) loaded_d = '1;
          else       loaded_d[wr_row] = 1'b1;
        end
        if (start) begin
          state_d = STREAM;
          cnt_d   = '0;
        end
      end
      STREAM: begin
        busy  = 1'b1;
        shift = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(LEN-1)) state_d = DONE;
      end
      DONE: begin
        done     = 1'b1;
        clr      = 1'b1;
        loaded_d = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      loaded_q  <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      loaded_q  <= loaded_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  assign wr_drop = wr_drop_q;

  for (genvar g = 0; g < DIM; g++) begin : g_row
    skew_row_shreg #(.BITS(BITS), .DIM(DIM), .ROW(g)) u_row (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (wr_ok && !col_w && (int'(wr_row) == g)),
      .clr_i      (clr),
      .shift_i    (shift),
      .row_i      (din),
`ifdef SKEW_FEED_TRANSPOSE_EN
      .poke_i     (wr_ok && col_w),
      .poke_idx_i (CW'(g) + CW'(wr_row)),
      .poke_data_i(din[g]),
`endif
      .head_o     (head[g]),
      .head_vld_o (head_vld[g])
    );

    assign dout[g]     = busy ? head[g] : '0;
    assign dout_vld[g] = busy && head_vld[g];
  end

endmodule

// File: tb/tb_skew_feed_buf.sv
// Self-checking bench for skew_feed_buf (DIM=4, BITS=8) against a tile-level model.
module tb_skew_feed_buf;

  localparam int DIM = 4;
  localparam int BITS = 8;
  localparam int LEN = 2*DIM-1;

  logic                   clk;
  logic                   rst_n;
  logic                   wr_en;
  logic [1:0]             wr_row;
  logic signed [BITS-1:0] din [DIM];
  logic                   start;
  logic                   busy;
  logic                   done;
  logic signed [BITS-1:0] dout [DIM];
  logic [DIM-1:0]         dout_vld;
  logic                   wr_drop;
`ifdef SKEW_FEED_TRANSPOSE_EN
  logic                   wr_col;
`endif

  int total;
  int bad;

  skew_feed_buf #(.BITS(BITS), .DIM(DIM)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_row  (wr_row),
`ifdef SKEW_FEED_TRANSPOSE_EN
    .wr_col  (wr_col),
`endif
    .din     (din),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .dout    (dout),
    .dout_vld(dout_vld),
    .wr_drop (wr_drop)
  );

  always #5 clk = ~clk;

  // Tile-level model: phase 0 idle, 1 streaming (m_cyc = stream cycle), 2 done.
  logic signed [BITS-1:0] m_tile [DIM][DIM];
  bit                     m_vld  [DIM][DIM];
  int                     m_phase;
  int                     m_cyc;
  bit                     m_drop;

  task automatic m_clear();
    for (int r = 0; r < DIM; r++)
      for (int k = 0; k < DIM; k++) begin
        m_tile[r][k] = '0;
        m_vld[r][k]  = 1'b0;
      end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_cyc   = 0;
      m_drop  = 1'b0;
      m_clear();
    end else begin
      m_drop = 1'b0;
      if (m_phase == 0) begin
        if (wr_en) begin
          for (int k = 0; k < DIM; k++) begin
            m_tile[wr_row][k] = din[k];
            m_vld[wr_row][k]  = 1'b1;
          end
        end
        if (start) begin
          m_phase = 1;
          m_cyc   = 0;
        end
      end else begin
        if (wr_en) m_drop = 1'b1;
        if (m_phase == 1) begin
          if (m_cyc == LEN-1) m_phase = 2;
          else m_cyc++;
        end else begin
          m_phase = 0;
          m_clear();
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pk_dout();
    logic [31:0] p;
    for (int r = 0; r < DIM; r++) p[8*r +: 8] = dout[r];
    return p;
  endfunction

  always @(negedge clk) begin
    logic [31:0] e_d;
    logic [3:0]  e_v;
    int          k;
    e_d = '0;
    e_v = '0;
    if (m_phase == 1) begin
      for (int r = 0; r < DIM; r++) begin
        k = m_cyc - r;
        if (k >= 0 && k < DIM && m_vld[r][k]) begin
          e_d[8*r +: 8] = m_tile[r][k];
          e_v[r] = 1'b1;
        end
      end
    end
    chk("busy",     int'(busy),      int'(m_phase == 1));
    chk("done",     int'(done),      int'(m_phase == 2));
    chk("dout",     int'(pk_dout()), int'(e_d));
    chk("dout_vld", int'(dout_vld),  int'(e_v));
    chk("wr_drop",  int'(wr_drop),   int'(m_drop));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int r, input int base, input int step);
    wr_en  = 1'b1;
    wr_row = 2'(r);
    for (int k = 0; k < DIM; k++) din[k] = 8'(base + step*k);
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    clk    = 1'b0;
    rst_n  = 1'b0;
    wr_en  = 1'b0;
    wr_row = '0;
    start  = 1'b0;
    total  = 0;
    bad    = 0;
`ifdef SKEW_FEED_TRANSPOSE_EN
    wr_col = 1'b0;
`endif
    for (int k = 0; k < DIM; k++) din[k] = '0;

    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dout", int'(pk_dout()), 0);
    chk("rst_vld",  int'(dout_vld), 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // full tile 1..16
    for (int r = 0; r < DIM; r++) load(r, 4*r + 1, 1);
    go();
    for (int c = 0; c <= LEN; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("full_c0_dout", int'(pk_dout()), 32'h00000001);
        chk("full_c0_vld",  int'(dout_vld), 4'b0001);
      end
      if (c == 3) begin
        chk("full_c3_dout", int'(pk_dout()), 32'h0D0A0704);
        chk("full_c3_vld",  int'(dout_vld), 4'b1111);
      end
      if (c == 6) begin
        chk("full_c6_d3",  int'(dout[3]), 16);
        chk("full_c6_vld", int'(dout_vld), 4'b1000);
      end
      if (c == 7) chk("full_c7_done", int'(done), 1);
    end
    @(negedge clk);
    chk("full_after_busy", int'(busy), 0);
    cyc();

    // only row 2, negative data
    load(2, -1, -1);
    go();
    for (int c = 0; c < LEN; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 5) chk("neg_row2", int'(dout[2]), 1 - c);
      chk("neg_other_vld", int'(dout_vld & 4'b1011), 0);
    end
    repeat (4) cyc();

    // write and start together
    wr_en  = 1'b1;
    wr_row = 2'd1;
    for (int k = 0; k < DIM; k++) din[k] = 8'(20 + k);
    start  = 1'b1;
    cyc();
    wr_en  = 1'b0;
    start  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("same_cyc_d1", int'(dout[1]), 20);
    chk("same_cyc_vld", int'(dout_vld), 4'b0010);
    repeat (10) cyc();

    // write during stream is dropped
    load(0, 50, 1);
    go();
    cyc();
    cyc();
    wr_en  = 1'b1;
    wr_row = 2'd0;
    for (int k = 0; k < DIM; k++) din[k] = 8'(99);
    cyc();
    wr_en = 1'b0;
    @(negedge clk);
    chk("drop_pulse", int'(wr_drop), 1);
    chk("drop_d0", int'(dout[0]), 53);
    @(negedge clk);
    chk("drop_once", int'(wr_drop), 0);
    repeat (8) cyc();

    // start during stream is ignored
    load(3, 30, 2);
    go();
    repeat (4) cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("late_start_done", int'(done), 1);
    @(negedge clk);
    chk("late_start_idle", int'(busy), 0);
    repeat (4) cyc();

    // reset mid-stream
    load(1, 5, 5);
    go();
    repeat (3) cyc();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_vld",  int'(dout_vld), 0);
    chk("mid_rst_dout", int'(pk_dout()), 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    load(0, 7, 1);
    go();
    @(negedge clk);
    chk("post_rst_d0",  int'(dout[0]), 7);
    chk("post_rst_vld", int'(dout_vld), 4'b0001);
    repeat (10) cyc();

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      wr_en  = ($urandom_range(0, 2) == 0);
      wr_row = 2'($urandom_range(0, 3));
      for (int k = 0; k < DIM; k++) din[k] = 8'($urandom);
      start  = ($urandom_range(0, 9) == 0);
      cyc();
    end
    wr_en = 1'b0;
    start = 1'b0;
    repeat (12) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
